// File: rtl/cp0_if.sv
// CP0 access bus between the M stage / next-PC logic and the CP0 unit.
// master: pipeline side (drives M-stage info); slave: cp0_unit.
interface cp0_if #(
    parameter int IM_WIDTH = 6
);
    logic                en;
    logic [4:0]          addr;
    logic [31:0]         wdata;
    logic [31:0]         vpc;
    logic                bd_in;
    logic [4:0]          exc_code;
    logic [IM_WIDTH-1:0] hw_int;
    logic                exl_clr;
    logic [31:0]         rdata;
    logic [31:0]         epc_out;
    logic                req;
    logic [31:0]         handler;

    modport master (
        output en, addr, wdata, vpc, bd_in, exc_code, hw_int, exl_clr,
        input  rdata, epc_out, req, handler
    );

    modport slave (
        input  en, addr, wdata, vpc, bd_in, exc_code, hw_int, exl_clr,
        output rdata, epc_out, req, handler
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller (SR, Cause, EPC) beside the M stage.
// Ports: clk, reset (async, active-high), bus (cp0_if.slave: mtc0/mfc0, victim info, req/handler).
module cp0_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          IM_WIDTH     = 6
) (
    input  logic   clk,
    input  logic   reset,
    cp0_if.slave   bus
);
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;

    logic [IM_WIDTH-1:0] im;
    logic                exl;
    logic                ie;
    logic                bd;
    logic [IM_WIDTH-1:0] ip;
    logic [4:0]          exc;
    logic [31:0]         epc;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req = (|(bus.hw_int & im)) & ie & ~exl;
    assign exc_req = (bus.exc_code != 5'd0) & ~exl;
    assign req     = int_req | exc_req;

    assign sr_val    = {16'b0, im, 8'b0, exl, ie};
    assign cause_val = {bd, 15'b0, ip, 3'b0, exc, 2'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im  <= '0;
            exl <= 1'b0;
            ie  <= 1'b0;
            bd  <= 1'b0;
            ip  <= '0;
            exc <= '0;
            epc <= '0;
        end else begin
            ip <= bus.hw_int;
            if (req) begin
                exl <= 1'b1;
                bd  <= bus.bd_in;
                exc <= int_req ? 5'd0 : bus.exc_code;
                epc <= bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
            end else begin
                if (bus.en && bus.addr == REG_SR) begin
                    im  <= bus.wdata[15:10];
                    exl <= bus.wdata[1];
                    ie  <= bus.wdata[0];
                end
                if (bus.en && bus.addr == REG_EPC)
                    epc <= bus.wdata;
                // eret overrides any EXL value written by a same-cycle mtc0
                if (bus.exl_clr)
                    exl <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rdata = 32'b0;
        unique case (bus.addr)
            REG_SR:    bus.rdata = sr_val;
            REG_CAUSE: bus.rdata = cause_val;
            REG_EPC:   bus.rdata = epc;
            default:   bus.rdata = 32'b0;
        endcase
    end

    assign bus.epc_out = epc;
    assign bus.req     = req;
    assign bus.handler = HANDLER_ADDR;
endmodule
